floor_dispatcher: RTL and testbench



---
 rtl/floor_pkg.sv | 24 ++
 rtl/floor_scan_sel.sv | 55 +++++
 rtl/floor_dispatcher.sv | 122 ++++++++++++
 tb/tb_floor_dispatcher.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/floor_pkg.sv
// floor_pkg: shared types for the elevator request dispatcher.
// Floor encoding, state enum and a one-hot helper.
package floor_pkg;

  localparam int NUM_FLOORS = 4;

  typedef logic [1:0] floor_t;

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    DWELL
  } state_t;

  function automatic logic [NUM_FLOORS-1:0] floor_onehot(
    input floor_t f
  );
    logic [NUM_FLOORS-1:0] oh;
    oh    = '0;
    oh[f] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/floor_scan_sel.sv
// floor_scan_sel: SCAN target picker, purely combinational.
// Nearest pending floor ahead; optional reversal when none ahead.
module floor_scan_sel
  import floor_pkg::*;
(
  input  logic [NUM_FLOORS-1:0] pending,
  input  floor_t                cf,
  input  logic                  dir_up,
  input  logic                  allow_rev,
  output logic                  valid,
  output floor_t                target,
  output logic                  new_dir_up
);

  logic   up_hit;
  logic   dn_hit;
  floor_t up_t;
  floor_t dn_t;

  // nearest pending floor strictly above and strictly below cf
  always_comb begin
    up_hit = 1'b0;
    up_t   = cf;
    dn_hit = 1'b0;
    dn_t   = cf;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (i > int'(cf) && pending[i]) begin
        up_hit = 1'b1;
        up_t   = floor_t'(i);
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i < int'(cf) && pending[i]) begin
        dn_hit = 1'b1;
        dn_t   = floor_t'(i);
      end
    end
  end

  // keep direction if anything lies ahead, else reverse if allowed
  always_comb begin
    valid      = 1'b0;
    target     = cf;
    new_dir_up = dir_up;
    if (dir_up ? up_hit : dn_hit) begin
      valid  = 1'b1;
      target = dir_up ? up_t : dn_t;
    end else if (allow_rev && (dir_up ? dn_hit : up_hit)) begin
      valid      = 1'b1;
      target     = dir_up ? dn_t : up_t;
      new_dir_up = ~dir_up;
    end
  end

endmodule

// File: rtl/floor_dispatcher.sv
// floor_dispatcher: latches call buttons, drives the elevator
// FSM target with SCAN ordering and times the door dwell.
module floor_dispatcher
  import floor_pkg::*;
#(
  parameter int DWELL_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] call_btn,
  input  floor_t                cf,
  output floor_t                floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  door_open,
  output logic                  dir_up,
  output logic                  busy
);

  localparam int CW = $clog2(DWELL_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DWELL_CYCLES - 1);

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [NUM_FLOORS-1:0] clear;
  logic                  sel_valid;
  floor_t                sel_target;
  logic                  sel_dir;
  logic                  arrived;
  logic                  retarget;

  assign arrived = (cf == floor);

  // reversal only on a fresh IDLE decision; MOVE just looks ahead
  floor_scan_sel u_sel (
    .pending    (pending),
    .cf         (cf),
    .dir_up     (dir_up),
    .allow_rev  (state == IDLE),
    .valid      (sel_valid),
    .target     (sel_target),
    .new_dir_up (sel_dir)
  );

  // a closer stop strictly before the current target
  assign retarget = sel_valid &&
                    (dir_up ? (sel_target < floor)
                            : (sel_target > floor));

  // floor being served on this edge; its button gets absorbed
  always_comb begin
    clear = '0;
    unique case (state)
      IDLE:    if (pending[cf]) clear = floor_onehot(cf);
      MOVE:    if (arrived) clear = floor_onehot(floor);
      DWELL:   clear = floor_onehot(cf);
      default: clear = '0;
    endcase
  end

  // request latch
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= (pending | call_btn) & ~clear;
    end
  end

  // dispatch FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      floor     <= '0;
      door_open <= 1'b0;
      dir_up    <= 1'b1;
      busy      <= 1'b0;
      cnt       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pending[cf]) begin
            state     <= DWELL;
            door_open <= 1'b1;
            busy      <= 1'b1;
            cnt       <= '0;
          end else if (sel_valid) begin
            state  <= MOVE;
            floor  <= sel_target;
            dir_up <= sel_dir;
            busy   <= 1'b1;
          end
        end
        MOVE: begin
          if (arrived) begin
            state     <= DWELL;
            door_open <= 1'b1;
            cnt       <= '0;
          end else if (retarget) begin
            floor <= sel_target;
          end
        end
        DWELL: begin
          if (cnt == LAST) begin
            state     <= IDLE;
            door_open <= 1'b0;
            busy      <= 1'b0;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          door_open <= 1'b0;
          busy      <= 1'b0;
          cnt       <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_floor_dispatcher.sv
// tb_floor_dispatcher: elevator model plus stop-order scoreboard.
// Expected stop floors queued at stimulus, popped on door open.
module tb_floor_dispatcher;
  import floor_pkg::*;

  localparam int TRAVEL = 4;
  localparam int DWELL  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] call_btn = '0;
  floor_t     cf = '0;
  floor_t     floor;
  logic [3:0] pending;
  logic       door_open;
  logic       dir_up;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;
  int exp_q[$];
  int tcnt = 0;
  logic prev_door = 1'b0;
  int dwell_len = 0;

  always #5 clk = ~clk;

  floor_dispatcher #(
    .DWELL_CYCLES(DWELL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .call_btn  (call_btn),
    .cf        (cf),
    .floor     (floor),
    .pending   (pending),
    .door_open (door_open),
    .dir_up    (dir_up),
    .busy      (busy)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // elevator: one floor every TRAVEL cycles toward floor
  always @(posedge clk) begin
    if (cf == floor) begin
      tcnt <= 0;
    end else if (tcnt == TRAVEL - 1) begin
      tcnt <= 0;
      cf   <= (cf < floor) ? floor_t'(cf + 1) : floor_t'(cf - 1);
    end else begin
      tcnt <= tcnt + 1;
    end
  end

  // scoreboard: each door opening pops the next expected stop
  always @(negedge clk) begin
    if (door_open && !prev_door) begin
      dwell_len = 1;
      if (exp_q.size() == 0)
        check("stop_unexpected", 32'(cf), 32'hFFFF_FFFF);
      else
        check("stop_floor", 32'(cf), 32'(exp_q.pop_front()));
    end else if (door_open) begin
      dwell_len++;
    end else if (prev_door) begin
      check("dwell_len", 32'(dwell_len), 32'(DWELL));
    end
    prev_door = door_open;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] m);
    call_btn = m;
    step();
    call_btn = '0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || door_open || pending != 0) && n < 300) begin
      step();
      n++;
    end
    check(tag, 32'({busy, door_open, pending}), 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    step(2);
    check("rst_floor", 32'(floor), 32'd0);
    check("rst_pend", 32'(pending), 32'd0);
    check("rst_door", 32'(door_open), 32'd0);
    check("rst_dir", 32'(dir_up), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    step(6);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_floor", 32'(floor), 32'd0);
    check("idle_pend", 32'(pending), 32'd0);

    exp_q.push_back(3);
    press(4'b1000);
    check("single_pend", 32'(pending), 32'd8);
    check("single_busy0", 32'(busy), 32'd0);
    step();
    check("single_floor", 32'(floor), 32'd3);
    check("single_dir", 32'(dir_up), 32'd1);
    check("single_busy", 32'(busy), 32'd1);
    wait_idle("single_done");
    check("single_cf", 32'(cf), 32'd3);

    exp_q.push_back(0);
    press(4'b0001);
    step();
    check("down_dir", 32'(dir_up), 32'd0);
    check("down_floor", 32'(floor), 32'd0);
    wait_idle("down_done");

    exp_q.push_back(2);
    exp_q.push_back(3);
    press(4'b1000);
    step();
    check("retgt_start", 32'(floor), 32'd3);
    n = 0;
    while (cf != 2'd1 && n < 100) begin
      step();
      n++;
    end
    check("retgt_cf1", 32'(cf), 32'd1);
    press(4'b0100);
    step();
    check("retgt_floor", 32'(floor), 32'd2);
    check("retgt_dir", 32'(dir_up), 32'd1);
    n = 0;
    while (floor != 2'd3 && n < 100) begin
      step();
      n++;
    end
    check("retgt_resume", 32'(floor), 32'd3);
    check("retgt_dir2", 32'(dir_up), 32'd1);
    wait_idle("retgt_done");

    check("rev_pre_dir", 32'(dir_up), 32'd1);
    exp_q.push_back(1);
    exp_q.push_back(0);
    press(4'b0011);
    check("rev_pend", 32'(pending), 32'd3);
    step();
    check("rev_dir", 32'(dir_up), 32'd0);
    check("rev_floor", 32'(floor), 32'd1);
    wait_idle("rev_done");
    check("rev_cf", 32'(cf), 32'd0);

    exp_q.push_back(2);
    press(4'b0100);
    n = 0;
    while (!door_open && n < 100) begin
      step();
      n++;
    end
    check("absorb_door", 32'(door_open), 32'd1);
    press(4'b0100);
    check("absorb_pend", 32'(pending), 32'd0);
    wait_idle("absorb_done");

    exp_q.push_back(2);
    exp_q.push_back(0);
    press(4'b0101);
    check("simul_pend", 32'(pending), 32'd5);
    step();
    check("simul_door", 32'(door_open), 32'd1);
    check("simul_pend2", 32'(pending), 32'd1);
    wait_idle("simul_done");

    press(4'b1010);
    check("mid_pend", 32'(pending), 32'd10);
    step();
    check("mid_busy", 32'(busy), 32'd1);
    check("mid_floor", 32'(floor), 32'd1);
    check("mid_dir", 32'(dir_up), 32'd1);
    exp_q.delete();
    rst = 1'b1;
    step();
    check("mid_rst_pend", 32'(pending), 32'd0);
    check("mid_rst_floor", 32'(floor), 32'd0);
    check("mid_rst_door", 32'(door_open), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    step(12);
    check("post_rst_pend", 32'(pending), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);

    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
